// File: rtl/tone_decoder.sv
// tone_decoder: measures half-periods of a square-wave input and decodes them into melody note codes
module tone_decoder #(
  parameter int TOL = 8,
  parameter int MATCH_N = 4,
  parameter int TIMEOUT = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sig_in,
  output logic [3:0]  note,
  output logic        note_valid,
  output logic        note_change,
  output logic [11:0] period
);
  typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;
  localparam logic [11:0] H [1:9] = '{12'd857, 12'd958, 12'd1017, 12'd1137, 12'd1283,
                                      12'd1437, 12'd1525, 12'd1713, 12'd1924};
  state_t state, state_nx;
  logic s1, s2, s3, edge_det, timeout, meas;
  logic [11:0] cnt;
  logic [3:0] cls, cls_nx, cand, mcnt, mcnt_nx;
  assign edge_det = s2 ^ s3;
  assign timeout = state == TRACK && !edge_det && cnt == 12'(TIMEOUT);
  assign mcnt_nx = cls == cand ? (mcnt == 4'd15 ? mcnt : mcnt + 4'd1) : 4'd1;
  // scanning downward lets the lowest matching code overwrite higher ones
  always_comb begin
    cls_nx = '0;
    for (int c = 9; c >= 1; c--)
      if ((cnt > H[c] ? cnt - H[c] : H[c] - cnt) <= 12'(TOL)) cls_nx = 4'(c);
  end
  always_comb begin
    state_nx = !enable ? IDLE : state == IDLE ? SYNC : (state == SYNC && edge_det) ? TRACK :
               timeout ? SYNC : state;
  end
  always_ff @(posedge clk) state <= !rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!rst) begin
      {s1, s2, s3, meas, note_change, note_valid} <= '0;
      cnt <= '0;
      cls <= '0;
      cand <= '0;
      mcnt <= '0;
      note <= '0;
      period <= '0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
      note_change <= 1'b0;
      meas <= 1'b0;
      if (!enable || state == IDLE) begin
        cnt <= '0;
        cls <= '0;
        cand <= '0;
        mcnt <= '0;
        note <= '0;
        note_valid <= 1'b0;
        period <= '0;
      end else begin
        cnt <= edge_det ? 12'd1 : state == SYNC ? 12'd0 : cnt == 12'hfff ? cnt : cnt + 12'd1;
        if (state == TRACK && edge_det) begin
          period <= cnt;
          cls <= cls_nx;
          meas <= 1'b1;
        end
        if (timeout) begin
          note <= '0;
          note_valid <= 1'b0;
          note_change <= note != 4'd0;
          cand <= '0;
          mcnt <= '0;
        end else if (meas) begin
          cand <= cls;
          mcnt <= mcnt_nx;
          if (mcnt_nx >= 4'(MATCH_N) && cls != note) begin
            note <= cls;
            note_valid <= cls != 4'd0;
            note_change <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/tone_decoder.md
# tone_decoder

Receive-side counterpart of the melody piezo driver. It samples an external square-wave line, such as a second board's piezo output or a comparator-conditioned microphone, and measures each half-period in `clk` cycles. Each half-period is classified against the fixed nine-note table the watch melody uses. A note index is published only once it has been stable for several consecutive half-periods. The block feeds the watch's "melody received" display and alarm-acknowledge logic.

## Interface
Parameters:
- `TOL`, 8: allowed ± deviation in clk cycles between a measured half-period and a table entry.
- `MATCH_N`, 4: consecutive identical classifications required to change `note`; range 2..15.
- `TIMEOUT`, 4000: clk cycles without an edge before the input is declared silent; must be > 1932 and < 4096.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; synchronous, active-low.
- `enable`, in, 1: decoder run enable.
- `sig_in`, in, 1: asynchronous square-wave input.
- `note`, out, 4: current decoded note code; 0 means silence or unknown.
- `note_valid`, out, 1: high while `note` != 0.
- `note_change`, out, 1: one-cycle pulse whenever `note` changes value.
- `period`, out, 12: last measured half-period in clk cycles.

## Operation
- **Input capture.** `sig_in` passes through a 2-flop synchronizer and then a 1-flop edge detector. Rising and falling edges are treated alike. An edge produces a single-cycle internal `edge` strobe.
- **Note table.** Codes map to half-periods H[c] as follows:
  - 1 = 857, 2 = 958, 3 = 1017, 4 = 1137, 5 = 1283
  - 6 = 1437, 7 = 1525, 8 = 1713, 9 = 1924
  - These values equal the driver's tone value + 1.
- **Classification.** A measurement p matches code c when |p − H[c]| <= TOL. The lowest matching c wins. If nothing matches, the classification is 0.
- **FSM states:**
  - IDLE: `enable` low. Counter, candidate and outputs held at 0.
  - SYNC: waiting for the first edge. That first edge only starts the counter and produces no measurement.
  - TRACK: each edge captures the count since the previous edge into `period`, then classifies it.
- **Transitions:**
  - IDLE → SYNC when `enable` = 1.
  - SYNC → TRACK on an edge.
  - TRACK → SYNC on timeout.
  - Any state → IDLE when `enable` = 0.
- **Half-period counter.** 12 bits. It is set to 1 in the cycle after an edge and increments every cycle. The value captured at the next edge equals the number of cycles between the two edges. It saturates at 4095.
- **Candidate tracking.**
  - If the new classification equals the stored candidate, the match count increments, saturating at 15.
  - Otherwise the candidate becomes the new classification and the match count becomes 1.
- **Note update.** When the match count reaches MATCH_N and the candidate != `note`:
  - `note` takes the candidate value.
  - `note_valid` becomes (candidate != 0).
  - `note_change` pulses.
  - A candidate of 0 therefore drops a note after MATCH_N consecutive unmatched half-periods.
- **Timeout.** The counter reaching TIMEOUT in TRACK does the following:
  - `note` is set to 0 and `note_valid` to 0.
  - `note_change` pulses only if `note` was nonzero.
  - The candidate and match count are cleared and the FSM enters SYNC.
  - `period` holds its last value.
- **Simultaneous edge and timeout.** The edge wins and is processed as a normal measurement.

## Timing
- **Reset.** `rst` = 0 at a clk edge clears the following, in that cycle, from any state, including mid-measurement:
  - `note` = 0, `note_valid` = 0, `note_change` = 0, `period` = 0
  - FSM = IDLE, and all counters, synchronizer and candidate state.
- **Edge detection latency.** A `sig_in` transition is seen as `edge` 3 cycles later (cycle E).
- **Measurement latency.** `period` and the classification register at E+1. The candidate, `note`, `note_valid` and `note_change` update at E+2.
- **Acquisition latency.** From the first edge of a clean tone, `note` becomes valid 2 cycles after the edge detect that completes the MATCH_N-th measurement. With defaults that is the 5th edge.
- **`note_change`.** High for exactly one cycle and never asserted on two consecutive cycles.
- **Enable.** `enable` falling clears all outputs to 0 in the next cycle without a `note_change` pulse. `enable` rising requires a fresh first edge before any measurement.

## Test plan
- **Clean tone.** Square wave with half-period 958 after reset and enable → `period` = 958; at the 5th edge +2 cycles, `note` = 2, `note_valid` = 1, exactly one `note_change` pulse.
- **Tolerance boundary.**
  - Half-period 966 → `note` = 2.
  - Half-period 967 → `note` stays 0 and `note_change` never pulses.
  - Half-period 849 → `note` = 1.
- **Note switch.** Stable 1437 (`note` = 6), then switch to 1283 → `note` stays 6 through 3 new half-periods and becomes 5 after the 4th, with one pulse.
- **Glitch rejection.** A single 500-cycle half-period inside a 1924 stream → `note` stays 9, no `note_change`.
- **Silence.** `sig_in` held constant while `note` = 3 → exactly 4000 cycles after the last counter restart, `note` = 0, `note_valid` = 0, one pulse. The next edge produces no `period` update.
- **Reset and enable mid-stream.**
  - `rst` = 0 for one cycle mid-stream → all outputs 0 on the following cycle; reacquisition takes 5 edges.
  - `enable` = 0 → all outputs 0 next cycle, no pulse.
